// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: measures high pulses, decodes them to bits,
// assembles 24-bit pixel words and marks frame boundaries on the low gap.
module ws2812_rx #(
   parameter int CLK_FRE    = 50_000_000,
   parameter int MIN_HIGH   = CLK_FRE / 10_000_000,
   parameter int BIT_THRESH = CLK_FRE / 10_000_000 * 6,
   parameter int MAX_HIGH   = CLK_FRE / 1_000_000 * 2,
   parameter int RESET_TIME = CLK_FRE / 1_000_000 * 50,
   parameter int PIX_IDX_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 WS2812_Di,
   output logic [23:0]          pix_data,
   output logic                 pix_valid,
   output logic [PIX_IDX_W-1:0] pix_idx,
   output logic                 frame_done,
   output logic                 bit_err
);

   localparam int HI_W = $clog2(MAX_HIGH + 2);
   localparam int LO_W = $clog2(RESET_TIME + 1);

   localparam logic [HI_W-1:0] HI_MIN = HI_W'(MIN_HIGH);
   localparam logic [HI_W-1:0] HI_ONE = HI_W'(BIT_THRESH);
   localparam logic [HI_W-1:0] HI_MAX = HI_W'(MAX_HIGH);
   localparam logic [HI_W-1:0] HI_SAT = HI_W'(MAX_HIGH + 1);
   localparam logic [LO_W-1:0] LO_GAP = LO_W'(RESET_TIME);
   localparam logic [LO_W-1:0] LO_PRE = LO_W'(RESET_TIME - 1);

   localparam logic [0:0] ST_SYNC = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   logic                 din_m, din_s, din_d;
   logic                 rise, fall, gap_hit;
   logic [HI_W-1:0]      hi_cnt;
   logic [LO_W-1:0]      lo_cnt;
   logic [0:0]           state;
   logic [23:0]          shift;
   logic [4:0]           bit_cnt;
   logic [PIX_IDX_W-1:0] idx;
   logic                 seen;
   logic                 word_rdy_p0;
   logic                 is_glitch, is_long, bit_val;

   assign rise      = din_s & ~din_d;
   assign fall      = ~din_s & din_d;
   // Fires only on the cycle the low count steps onto RESET_TIME.
   assign gap_hit   = ~din_s & ~fall & (lo_cnt == LO_PRE);
   assign is_glitch = hi_cnt < HI_MIN;
   assign is_long   = hi_cnt > HI_MAX;
   assign bit_val   = hi_cnt >= HI_ONE;

   // Two-flop synchroniser plus one delay stage for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_m <= 1'b0;
         din_s <= 1'b0;
         din_d <= 1'b0;
      end else begin
         din_m <= WS2812_Di;
         din_s <= din_m;
         din_d <= din_s;
      end
   end

   // Pulse width counters; the rise cycle counts as the first high cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_cnt <= '0;
         lo_cnt <= '0;
      end else begin
         if (rise)
            hi_cnt <= HI_W'(1);
         else if (din_s && hi_cnt < HI_SAT)
            hi_cnt <= hi_cnt + HI_W'(1);

         if (fall)
            lo_cnt <= LO_W'(1);
         else if (!din_s && lo_cnt < LO_GAP)
            lo_cnt <= lo_cnt + LO_W'(1);
      end
   end

   // Decode state machine, word assembly and output pulse generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_SYNC;
         shift       <= '0;
         bit_cnt     <= '0;
         idx         <= '0;
         seen        <= 1'b0;
         word_rdy_p0 <= 1'b0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         pix_idx     <= '0;
         frame_done  <= 1'b0;
         bit_err     <= 1'b0;
      end else begin
         pix_valid   <= 1'b0;
         frame_done  <= 1'b0;
         bit_err     <= 1'b0;
         word_rdy_p0 <= 1'b0;

         // Output stage: publish the word completed on the previous cycle.
         if (word_rdy_p0) begin
            pix_data  <= shift;
            pix_valid <= 1'b1;
            pix_idx   <= idx;
            idx       <= idx + PIX_IDX_W'(1);
         end

         case (state)
            ST_SYNC: begin
               if (gap_hit)
                  state <= ST_RECV;
            end
            default: begin
               if (fall) begin
                  if (is_long) begin
                     bit_err <= 1'b1;
                     bit_cnt <= '0;
                     idx     <= '0;
                     seen    <= 1'b0;
                     state   <= ST_SYNC;
                  end else if (!is_glitch) begin
                     shift[bit_cnt] <= bit_val;
                     seen           <= 1'b1;
                     if (bit_cnt == 5'd23) begin
                        bit_cnt     <= '0;
                        word_rdy_p0 <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end else if (gap_hit) begin
                  frame_done <= seen;
                  bit_err    <= (bit_cnt != 5'd0);
                  bit_cnt    <= '0;
                  idx        <= '0;
                  seen       <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx at 50 MHz timing (1 = 40/20, 0 = 20/40 cycles).
module tb_ws2812_rx;

   logic        clk;
   logic        rst_n;
   logic        WS2812_Di;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic [7:0]  pix_idx;
   logic        frame_done;
   logic        bit_err;

   int n_tests = 0;
   int n_fail  = 0;

   int          nv, nfd, nerr, nboth;
   logic [23:0] mon_data [0:15];
   logic [7:0]  mon_idx  [0:15];

   ws2812_rx #(.CLK_FRE(50_000_000), .PIX_IDX_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .WS2812_Di  (WS2812_Di),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_idx    (pix_idx),
      .frame_done (frame_done),
      .bit_err    (bit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event recorder, sampled on the falling edge.
   always @(negedge clk) begin
      if (pix_valid) begin
         if (nv < 16) begin
            mon_data[nv] = pix_data;
            mon_idx[nv]  = pix_idx;
         end
         nv = nv + 1;
      end
      if (frame_done) nfd = nfd + 1;
      if (bit_err) nerr = nerr + 1;
      if (frame_done && bit_err) nboth = nboth + 1;
   end

   task automatic clear_mon();
      nv = 0; nfd = 0; nerr = 0; nboth = 0;
      for (int i = 0; i < 16; i++) begin
         mon_data[i] = 'x;
         mon_idx[i]  = 'x;
      end
   endtask

   task automatic idle(input int n);
      WS2812_Di = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      WS2812_Di = 1'b1;
      repeat (hi) @(negedge clk);
      WS2812_Di = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) pulse(40, 20);
      else   pulse(20, 40);
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int i = 0; i < 24; i++) send_bit(w[i]);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      WS2812_Di = 1'b0;
      clear_mon();
      #2 rst_n = 1'b0;
      #3;
      n_tests++; if (pix_data !== 24'h0) begin $display("FAIL reset_pix_data: got %h expected %h", pix_data, 24'h0); n_fail++; end
      n_tests++; if (pix_valid !== 1'b0) begin $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); n_fail++; end
      n_tests++; if (pix_idx !== 8'h0) begin $display("FAIL reset_pix_idx: got %h expected 00", pix_idx); n_fail++; end
      n_tests++; if (frame_done !== 1'b0) begin $display("FAIL reset_frame_done: got %b expected 0", frame_done); n_fail++; end
      n_tests++; if (bit_err !== 1'b0) begin $display("FAIL reset_bit_err: got %b expected 0", bit_err); n_fail++; end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2600);
      send_word(24'h000001);
      idle(2510);
      n_tests++; if (nv !== 1) begin $display("FAIL t1_valid_count: got %0d expected 1", nv); n_fail++; end
      n_tests++; if (mon_data[0] !== 24'h000001) begin $display("FAIL t1_data: got %h expected %h", mon_data[0], 24'h000001); n_fail++; end
      n_tests++; if (mon_idx[0] !== 8'd0) begin $display("FAIL t1_idx: got %0d expected 0", mon_idx[0]); n_fail++; end
      n_tests++; if (nfd !== 1) begin $display("FAIL t1_frame_done: got %0d expected 1", nfd); n_fail++; end
      n_tests++; if (nerr !== 0) begin $display("FAIL t1_bit_err: got %0d expected 0", nerr); n_fail++; end
   endtask

   task automatic test_frame();
      logic [23:0] exp_d [0:2];
      exp_d[0] = 24'hA55A0F; exp_d[1] = 24'hFFFFFF; exp_d[2] = 24'h000000;
      clear_mon();
      for (int k = 0; k < 3; k++) send_word(exp_d[k]);
      idle(2600);
      n_tests++; if (nv !== 3) begin $display("FAIL t2_valid_count: got %0d expected 3", nv); n_fail++; end
      for (int k = 0; k < 3; k++) begin
         n_tests++; if (mon_data[k] !== exp_d[k]) begin $display("FAIL t2_data%0d: got %h expected %h", k, mon_data[k], exp_d[k]); n_fail++; end
         n_tests++; if (mon_idx[k] !== 8'(k)) begin $display("FAIL t2_idx%0d: got %0d expected %0d", k, mon_idx[k], k); n_fail++; end
      end
      n_tests++; if (nfd !== 1) begin $display("FAIL t2_frame_done: got %0d expected 1", nfd); n_fail++; end
      clear_mon();
      send_word(24'h5A5A5A);
      idle(2600);
      n_tests++; if (nv !== 1) begin $display("FAIL t2_restart_count: got %0d expected 1", nv); n_fail++; end
      n_tests++; if (mon_data[0] !== 24'h5A5A5A) begin $display("FAIL t2_restart_data: got %h expected %h", mon_data[0], 24'h5A5A5A); n_fail++; end
      n_tests++; if (mon_idx[0] !== 8'd0) begin $display("FAIL t2_restart_idx: got %0d expected 0", mon_idx[0]); n_fail++; end
   endtask

   task automatic test_widths();
      clear_mon();
      pulse(4, 40);
      pulse(5, 40);
      pulse(29, 40);
      pulse(30, 40);
      for (int i = 0; i < 21; i++) send_bit(1'b1);
      idle(2600);
      n_tests++; if (nv !== 1) begin $display("FAIL t3_valid_count: got %0d expected 1", nv); n_fail++; end
      n_tests++; if (mon_data[0] !== 24'hFFFFFC) begin $display("FAIL t3_width_word: got %h expected %h", mon_data[0], 24'hFFFFFC); n_fail++; end
      n_tests++; if (nerr !== 0) begin $display("FAIL t3_bit_err: got %0d expected 0", nerr); n_fail++; end
   endtask

   task automatic test_long_pulse();
      clear_mon();
      pulse(120, 40);
      n_tests++; if (nerr !== 1) begin $display("FAIL t4_err_on_long: got %0d expected 1", nerr); n_fail++; end
      send_word(24'hFFFFFF);
      idle(2600);
      n_tests++; if (nv !== 0) begin $display("FAIL t4_ignored_in_sync: got %0d expected 0", nv); n_fail++; end
      n_tests++; if (nfd !== 0) begin $display("FAIL t4_no_fd_in_sync: got %0d expected 0", nfd); n_fail++; end
      send_word(24'h123456);
      idle(2600);
      n_tests++; if (nv !== 1) begin $display("FAIL t4_valid_count: got %0d expected 1", nv); n_fail++; end
      n_tests++; if (mon_data[0] !== 24'h123456) begin $display("FAIL t4_data: got %h expected %h", mon_data[0], 24'h123456); n_fail++; end
      n_tests++; if (mon_idx[0] !== 8'd0) begin $display("FAIL t4_idx: got %0d expected 0", mon_idx[0]); n_fail++; end
      n_tests++; if (nerr !== 1) begin $display("FAIL t4_err_total: got %0d expected 1", nerr); n_fail++; end
   endtask

   task automatic test_partial();
      clear_mon();
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      idle(2600);
      n_tests++; if (nboth !== 1) begin $display("FAIL t5_err_fd_same_cycle: got %0d expected 1", nboth); n_fail++; end
      n_tests++; if (nerr !== 1) begin $display("FAIL t5_err_count: got %0d expected 1", nerr); n_fail++; end
      n_tests++; if (nfd !== 1) begin $display("FAIL t5_fd_count: got %0d expected 1", nfd); n_fail++; end
      n_tests++; if (nv !== 0) begin $display("FAIL t5_no_valid: got %0d expected 0", nv); n_fail++; end
      clear_mon();
      pulse(3, 40);
      idle(2600);
      n_tests++; if (nfd !== 0) begin $display("FAIL t5_empty_gap_fd: got %0d expected 0", nfd); n_fail++; end
      n_tests++; if (nerr !== 0) begin $display("FAIL t5_empty_gap_err: got %0d expected 0", nerr); n_fail++; end
   endtask

   task automatic test_reset_mid_word();
      for (int i = 0; i < 10; i++) send_bit(1'b0);
      #1 rst_n = 1'b0;
      #1;
      n_tests++; if (pix_data !== 24'h0) begin $display("FAIL t6_reset_data: got %h expected %h", pix_data, 24'h0); n_fail++; end
      n_tests++; if ({pix_valid, frame_done, bit_err} !== 3'b000) begin $display("FAIL t6_reset_pulses: got %b expected 000", {pix_valid, frame_done, bit_err}); n_fail++; end
      n_tests++; if (pix_idx !== 8'h0) begin $display("FAIL t6_reset_idx: got %h expected 00", pix_idx); n_fail++; end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      send_word(24'hABCDEF);
      n_tests++; if (nv !== 0) begin $display("FAIL t6_ignored_after_reset: got %0d expected 0", nv); n_fail++; end
      idle(2600);
      send_word(24'h00C0DE);
      idle(2600);
      n_tests++; if (nv !== 1) begin $display("FAIL t6_valid_count: got %0d expected 1", nv); n_fail++; end
      n_tests++; if (mon_data[0] !== 24'h00C0DE) begin $display("FAIL t6_data: got %h expected %h", mon_data[0], 24'h00C0DE); n_fail++; end
      n_tests++; if (mon_idx[0] !== 8'd0) begin $display("FAIL t6_idx: got %0d expected 0", mon_idx[0]); n_fail++; end
      n_tests++; if (nerr !== 0) begin $display("FAIL t6_bit_err: got %0d expected 0", nerr); n_fail++; end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_widths();
      test_long_pulse();
      test_partial();
      test_reset_mid_word();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
